// File: rtl/sram_like_arb_pkg.sv
// Shared types and constants for the two-master SRAM-like arbiter.
// Master ids double as FIFO payload and as the select for the slave-side mux.
package sram_like_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Fixed priority: the data port wins whenever it requests.
  function automatic logic fixed_winner(input logic m1_req);
    return m1_req ? ID_DATA : ID_INST;
  endfunction

  // Round-robin: on contention the master not granted last time wins.
  function automatic logic rr_winner(input logic m0_req, input logic m1_req,
                                     input logic last_grant);
    logic w;
    if (m0_req && m1_req) begin
      w = ~last_grant;
    end else if (m1_req) begin
      w = ID_DATA;
    end else begin
      w = ID_INST;
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_like_arb_id_fifo.sv
// In-order FIFO of 1-bit owner ids for accepted-but-unanswered transactions.
// Head is read combinationally so responses route with zero added latency.
module sram_like_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_id,
  input  logic                   pop,
  output logic                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_id;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (m0 = instruction fetch, m1 = data) to one-slave SRAM-like arbiter.
// Define SRAM_LIKE_ARB_RR_EN for round-robin; otherwise m1 has fixed priority.
module sram_like_arbiter
  import sram_like_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   m0_req,
  input  logic                   m0_wr,
  input  logic [1:0]             m0_size,
  input  logic [ADDR_W-1:0]      m0_addr,
  input  logic [DATA_W-1:0]      m0_wdata,
  output logic                   m0_addr_ok,
  output logic                   m0_data_ok,
  output logic [DATA_W-1:0]      m0_rdata,

  input  logic                   m1_req,
  input  logic                   m1_wr,
  input  logic [1:0]             m1_size,
  input  logic [ADDR_W-1:0]      m1_addr,
  input  logic [DATA_W-1:0]      m1_wdata,
  output logic                   m1_addr_ok,
  output logic                   m1_data_ok,
  output logic [DATA_W-1:0]      m1_rdata,

  output logic                   s_req,
  output logic                   s_wr,
  output logic [1:0]             s_size,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  input  logic                   s_addr_ok,
  input  logic                   s_data_ok,
  input  logic [DATA_W-1:0]      s_rdata,

  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_unexp_ok
);

  arb_state_e state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       winner;
  logic       sel;
  logic       req_int;
  logic       fire_int;
  logic       grant_fire;
  logic       resp_fire;
  logic       fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       err_reg;
  logic [1:0] addr_ok_vec;
  logic [1:0] data_ok_vec;

`ifdef SRAM_LIKE_ARB_RR_EN
  logic last_grant_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= ID_INST;
    end else if (grant_fire) begin
      last_grant_reg <= sel;
    end
  end

  assign winner = rr_winner(m0_req, m1_req, last_grant_reg);
`else
  assign winner = fixed_winner(m1_req);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
      owner_reg <= ID_INST;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    sel        = owner_reg;
    req_int    = 1'b0;
    fire_int   = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        sel = winner;
        // Full uses the registered count: a same-cycle pop frees the slot next cycle.
        if (!fifo_full && (m0_req || m1_req)) begin
          req_int = 1'b1;
          if (s_addr_ok) begin
            fire_int = 1'b1;
          end else begin
            state_next = ARB_HOLD;
            owner_next = winner;
          end
        end
      end
      ARB_HOLD: begin
        req_int = 1'b1;
        if (s_addr_ok) begin
          fire_int   = 1'b1;
          state_next = ARB_IDLE;
        end
      end
    endcase
  end

  // Handshake outputs are forced quiet for as long as reset is held.
  assign grant_fire = fire_int & ~rst;
  assign resp_fire  = s_data_ok & ~fifo_empty & ~rst;

  assign s_req   = req_int & ~rst;
  assign s_wr    = sel ? m1_wr    : m0_wr;
  assign s_size  = sel ? m1_size  : m0_size;
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  sram_like_arb_id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_fire),
    .push_id (sel),
    .pop     (resp_fire),
    .head    (fifo_head),
    .count   (outstanding),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign addr_ok_vec[gi] = grant_fire & (sel == 1'(gi));
      assign data_ok_vec[gi] = resp_fire & (fifo_head == 1'(gi));
    end
  endgenerate

  assign m0_addr_ok = addr_ok_vec[0];
  assign m1_addr_ok = addr_ok_vec[1];
  assign m0_data_ok = data_ok_vec[0];
  assign m1_data_ok = data_ok_vec[1];
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // A response with nothing outstanding means the slave and arbiter disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (s_data_ok && fifo_empty) begin
      err_reg <= 1'b1;
    end
  end

  assign err_unexp_ok = err_reg;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: scenario tasks plus a response scoreboard.
module tb_sram_like_arbiter;
  import sram_like_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  outstanding;
  logic        err_unexp_ok;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_last = ID_INST;

  sram_like_arbiter #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata),
    .outstanding(outstanding), .err_unexp_ok(err_unexp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every data_ok must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && (m0_data_ok || m1_data_ok)) begin
      checks++;
      if (m0_data_ok && m1_data_ok) begin
        errors++;
        $display("FAIL data_ok_both: m0_data_ok=%b m1_data_ok=%b, expected one-hot", m0_data_ok, m1_data_ok);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_ok_unexpected: m0_data_ok=%b m1_data_ok=%b, expected none", m0_data_ok, m1_data_ok);
      end else begin
        e = exp_q.pop_front();
        if (m1_data_ok !== e.id || (e.id ? m1_rdata : m0_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL data_ok_route: got m1_data_ok=%b rdata=%h, expected id=%0d rdata=%h",
                   m1_data_ok, (m1_data_ok ? m1_rdata : m0_rdata), e.id, e.rdata);
        end else begin
          $display("resp id=%0d rdata=%h", e.id, e.rdata);
        end
      end
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_size = SIZE_WORD; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_size = SIZE_WORD; m1_addr = '0; m1_wdata = '0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  task automatic accept(input logic id, input logic [31:0] rdata);
    exp_q.push_back('{id: id, rdata: rdata});
    exp_last = id;
  endtask

  function automatic logic exp_winner();
`ifdef SRAM_LIKE_ARB_RR_EN
    return ~exp_last;
`else
    return ID_DATA;
`endif
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_data_ok = 1;
      s_rdata = (exp_q.size() != 0) ? exp_q[0].rdata : 32'h0;
    end
    @(negedge clk);
    s_data_ok = 0;
    #1;
    checks++;
    if (exp_q.size() != 0 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL drain: pending=%0d outstanding=%0d, expected 0 and 0", exp_q.size(), outstanding);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 1;
    @(negedge clk); #1;
    checks++;
    if (s_req !== 0 || m1_addr_ok !== 0 || m0_addr_ok !== 0 || m0_data_ok !== 0 ||
        m1_data_ok !== 0 || outstanding !== 0 || err_unexp_ok !== 0) begin
      errors++;
      $display("FAIL reset_outputs: s_req=%b aok=%b%b dok=%b%b out=%0d err=%b, expected all 0",
               s_req, m1_addr_ok, m0_addr_ok, m1_data_ok, m0_data_ok, outstanding, err_unexp_ok);
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    #1;
    checks++;
    if (err_unexp_ok !== 0 || outstanding !== 0) begin
      errors++;
      $display("FAIL reset_release: err=%b out=%0d, expected 0 0", err_unexp_ok, outstanding);
    end
    $display("reset done");
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m1_req = 1; m1_wr = 0; m1_addr = 32'h1000; s_addr_ok = 1;
    #1;
    checks++;
    if (s_req !== 1 || s_addr !== 32'h1000 || m1_addr_ok !== 1 || m0_addr_ok !== 0) begin
      errors++;
      $display("FAIL single_grant: s_req=%b s_addr=%h m1_aok=%b m0_aok=%b, expected 1 00001000 1 0",
               s_req, s_addr, m1_addr_ok, m0_addr_ok);
    end
    accept(ID_DATA, 32'hDEADBEEF);
    @(negedge clk);
    m1_req = 0; s_addr_ok = 0;
    #1;
    checks++;
    if (outstanding !== 3'd1) begin
      errors++;
      $display("FAIL single_outstanding: got %0d, expected 1", outstanding);
    end
    @(negedge clk);
    @(negedge clk);
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (m1_data_ok !== 1 || m0_data_ok !== 0 || m1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_resp: m1_dok=%b m0_dok=%b rdata=%h, expected 1 0 deadbeef",
               m1_data_ok, m0_data_ok, m1_rdata);
    end
    drain(0);
    $display("single read done");
  endtask

  task automatic test_priority();
    logic w;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      m0_req = 1; m0_addr = 32'h100 + 32'(r);
      m1_req = 1; m1_addr = 32'h200 + 32'(r);
      s_addr_ok = 1;
      w = exp_winner();
      #1;
      checks++;
      if (s_addr !== (w ? m1_addr : m0_addr) || m1_addr_ok !== w || m0_addr_ok !== ~w) begin
        errors++;
        $display("FAIL prio_first r%0d: s_addr=%h aok=%b%b, expected winner m%0d", r, s_addr,
                 m1_addr_ok, m0_addr_ok, w);
      end
      accept(w, 32'hA000_0000 + 32'(2 * r));
      @(negedge clk);
      if (w) m1_req = 0; else m0_req = 0;
      #1;
      checks++;
      if (s_addr !== (w ? m0_addr : m1_addr) || m1_addr_ok !== ~w || m0_addr_ok !== w) begin
        errors++;
        $display("FAIL prio_second r%0d: s_addr=%h aok=%b%b, expected winner m%0d", r, s_addr,
                 m1_addr_ok, m0_addr_ok, ~w);
      end
      accept(~w, 32'hA000_0001 + 32'(2 * r));
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0; s_addr_ok = 0;
    #1;
    checks++;
    if (outstanding !== 3'd4) begin
      errors++;
      $display("FAIL prio_outstanding: got %0d, expected 4", outstanding);
    end
    drain(4);
    $display("priority done");
  endtask

  task automatic test_hold();
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h3000;
    #1;
    checks++;
    if (s_req !== 1 || s_addr !== 32'h3000 || m0_addr_ok !== 0) begin
      errors++;
      $display("FAIL hold_c0: s_req=%b s_addr=%h m0_aok=%b, expected 1 00003000 0", s_req, s_addr, m0_addr_ok);
    end
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      m1_req = 1; m1_addr = 32'h4000;
      #1;
      checks++;
      if (s_req !== 1 || s_addr !== 32'h3000 || m0_addr_ok !== 0 || m1_addr_ok !== 0) begin
        errors++;
        $display("FAIL hold_c%0d: s_req=%b s_addr=%h aok=%b%b, expected 1 00003000 00",
                 c, s_req, s_addr, m1_addr_ok, m0_addr_ok);
      end
    end
    @(negedge clk);
    s_addr_ok = 1;
    #1;
    checks++;
    if (s_addr !== 32'h3000 || m0_addr_ok !== 1 || m1_addr_ok !== 0) begin
      errors++;
      $display("FAIL hold_accept: s_addr=%h aok=%b%b, expected 00003000 01", s_addr, m1_addr_ok, m0_addr_ok);
    end
    accept(ID_INST, 32'hC0C0_0000);
    @(negedge clk);
    m0_req = 0;
    #1;
    checks++;
    if (s_addr !== 32'h4000 || m1_addr_ok !== 1 || m0_addr_ok !== 0) begin
      errors++;
      $display("FAIL hold_next: s_addr=%h aok=%b%b, expected 00004000 10", s_addr, m1_addr_ok, m0_addr_ok);
    end
    accept(ID_DATA, 32'hC0C0_0001);
    @(negedge clk);
    m1_req = 0; s_addr_ok = 0;
    drain(2);
    $display("hold done");
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m0_req = 1; m0_addr = 32'h2000 + 32'(4 * k); s_addr_ok = 1;
      #1;
      checks++;
      if (m0_addr_ok !== 1) begin
        errors++;
        $display("FAIL full_fill%0d: m0_aok=%b, expected 1", k, m0_addr_ok);
      end
      accept(ID_INST, 32'hB000_0000 + 32'(k));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      m0_addr = 32'h2010;
      #1;
      checks++;
      if (s_req !== 0 || m0_addr_ok !== 0 || outstanding !== 3'd4) begin
        errors++;
        $display("FAIL full_block%0d: s_req=%b m0_aok=%b out=%0d, expected 0 0 4", c, s_req, m0_addr_ok, outstanding);
      end
    end
    @(negedge clk);
    s_data_ok = 1; s_rdata = exp_q[0].rdata;
    #1;
    checks++;
    if (s_req !== 0 || m0_addr_ok !== 0) begin
      errors++;
      $display("FAIL full_pop_cycle: s_req=%b m0_aok=%b, expected 0 0", s_req, m0_addr_ok);
    end
    @(negedge clk);
    s_data_ok = 0;
    #1;
    checks++;
    if (s_req !== 1 || m0_addr_ok !== 1 || outstanding !== 3'd3 || s_addr !== 32'h2010) begin
      errors++;
      $display("FAIL full_unblock: s_req=%b m0_aok=%b out=%0d s_addr=%h, expected 1 1 3 00002010",
               s_req, m0_addr_ok, outstanding, s_addr);
    end
    accept(ID_INST, 32'hB000_0004);
    @(negedge clk);
    m0_req = 0; s_addr_ok = 0;
    drain(4);
    $display("full done");
  endtask

  task automatic test_unexpected();
    @(negedge clk); #1;
    checks++;
    if (err_unexp_ok !== 0) begin
      errors++;
      $display("FAIL unexp_before: err=%b, expected 0", err_unexp_ok);
    end
    @(negedge clk);
    s_data_ok = 1; s_rdata = 32'h5555_5555;
    #1;
    checks++;
    if (m0_data_ok !== 0 || m1_data_ok !== 0) begin
      errors++;
      $display("FAIL unexp_dok: dok=%b%b, expected 00", m1_data_ok, m0_data_ok);
    end
    @(negedge clk);
    s_data_ok = 0;
    #1;
    checks++;
    if (err_unexp_ok !== 1) begin
      errors++;
      $display("FAIL unexp_set: err=%b, expected 1", err_unexp_ok);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_unexp_ok !== 1) begin
      errors++;
      $display("FAIL unexp_sticky: err=%b, expected 1", err_unexp_ok);
    end
    $display("unexpected response done");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m1_req = 1; m1_addr = 32'h6000; s_addr_ok = 1;
    accept(ID_DATA, 32'h0);
    @(negedge clk);
    m1_req = 0; m0_req = 1; m0_addr = 32'h7000;
    accept(ID_INST, 32'h0);
    @(negedge clk);
    m0_req = 0; m1_req = 1; m1_addr = 32'h6004; s_addr_ok = 0;
    #1;
    checks++;
    if (outstanding !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: out=%0d, expected 2", outstanding);
    end
    @(negedge clk);
    m1_req = 0; m0_req = 1; m0_addr = 32'h7100; s_addr_ok = 1;
    rst = 1;
    #1;
    checks++;
    if (outstanding !== 0 || s_req !== 0 || m0_addr_ok !== 0 || m1_addr_ok !== 0 || err_unexp_ok !== 0) begin
      errors++;
      $display("FAIL rstmid_clear: out=%0d s_req=%b aok=%b%b err=%b, expected 0 0 00 0",
               outstanding, s_req, m1_addr_ok, m0_addr_ok, err_unexp_ok);
    end
    exp_q.delete();
    exp_last = ID_INST;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (s_addr !== 32'h7100 || m0_addr_ok !== 1) begin
      errors++;
      $display("FAIL rstmid_idle: s_addr=%h m0_aok=%b, expected 00007100 1", s_addr, m0_addr_ok);
    end
    accept(ID_INST, 32'h7777_0000);
    @(negedge clk);
    m0_req = 0; s_addr_ok = 0;
    drain(1);
    @(negedge clk);
    s_data_ok = 1;
    #1;
    checks++;
    if (m0_data_ok !== 0 || m1_data_ok !== 0) begin
      errors++;
      $display("FAIL rstmid_stray_dok: dok=%b%b, expected 00", m1_data_ok, m0_data_ok);
    end
    @(negedge clk);
    s_data_ok = 0;
    #1;
    checks++;
    if (err_unexp_ok !== 1) begin
      errors++;
      $display("FAIL rstmid_stray_err: err=%b, expected 1", err_unexp_ok);
    end
    $display("reset mid-transaction done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_hold();
    test_full();
    test_unexpected();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
